// File: rtl/bsg_subtractor_serial_borrow.sv
// Serial unsigned subtractor: a_i - b_i, chunk_p bits per cycle, LSB first.
// Ports: clk_i, reset_n_i, v_i/a_i/b_i/ready_o in, v_o/d_o/borrow_o/yumi_i out.
module bsg_subtractor_serial_borrow #(
  parameter int width_p = 32,
  parameter int chunk_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] d_o,
  output logic               borrow_o,
  input  logic               yumi_i
);

  localparam int chunks_lp = width_p / chunk_p;
  localparam int cnt_w_lp =
    (chunks_lp > 1) ? $clog2(chunks_lp) : 1;
  localparam logic [cnt_w_lp-1:0] last_lp =
    cnt_w_lp'(chunks_lp - 1);

  if (width_p % chunk_p != 0) begin : g_bad_chunk
    $error("width_p must be a multiple of chunk_p");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e              state_r;
  state_e              state_n;
  logic [width_p-1:0]  a_r;
  logic [width_p-1:0]  b_r;
  logic [width_p-1:0]  d_r;
  logic                borrow_r;
  logic [cnt_w_lp-1:0] cnt_r;
  logic [chunk_p:0]    diff;

  // One extra bit so the borrow out falls into bit chunk_p.
  always_comb begin
    diff = {1'b0, a_r[chunk_p-1:0]}
         - {1'b0, b_r[chunk_p-1:0]}
         - (chunk_p + 1)'(borrow_r);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  always_comb begin
    state_n = state_r;
    ready_o = 1'b0;
    v_o     = 1'b0;
    unique case (state_r)
      IDLE: begin
        ready_o = 1'b1;
        if (v_i) state_n = BUSY;
      end
      BUSY: begin
        if (cnt_r == last_lp) state_n = DONE;
      end
      DONE: begin
        v_o = 1'b1;
        if (yumi_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      a_r      <= '0;
      b_r      <= '0;
      d_r      <= '0;
      borrow_r <= 1'b0;
      cnt_r    <= '0;
    end else begin
      if (state_r == IDLE && v_i) begin
        a_r      <= a_i;
        b_r      <= b_i;
        borrow_r <= 1'b0;
        cnt_r    <= '0;
      end else if (state_r == BUSY) begin
        // Operands shift down so the active chunk is always at the LSBs.
        a_r      <= a_r >> chunk_p;
        b_r      <= b_r >> chunk_p;
        borrow_r <= diff[chunk_p];
        d_r[cnt_r*chunk_p +: chunk_p] <= diff[chunk_p-1:0];
        cnt_r    <= cnt_r + 1'b1;
      end
    end
  end

  assign d_o      = d_r;
  assign borrow_o = borrow_r;

  yumi_only_when_valid: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    yumi_i |-> v_o
  ) else $error("yumi_i asserted while v_o=0");

endmodule

// File: tb/tb_bsg_subtractor_serial_borrow.sv
// Directed and random checks for the serial subtractor.
// Expected values are hand-computed or from a 33-bit reference subtract.
module tb_bsg_subtractor_serial_borrow;

  logic        clk;
  logic        reset_n;
  logic        v_i;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        v_o;
  logic [31:0] d;
  logic        borrow;
  logic        yumi;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  bsg_subtractor_serial_borrow #(
    .width_p(32),
    .chunk_p(8)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .v_i      (v_i),
    .a_i      (a),
    .b_i      (b),
    .ready_o  (ready),
    .v_o      (v_o),
    .d_o      (d),
    .borrow_o (borrow),
    .yumi_i   (yumi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Accept one pair, wait for v_o, check latency and result, consume it.
  task automatic do_op(input string tag,
                       input logic [31:0] aa,
                       input logic [31:0] bb,
                       input logic [31:0] exp_d,
                       input logic        exp_b);
    int lat;
    chk({tag, "_ready"}, 64'(ready), 64'd1);
    a   = aa;
    b   = bb;
    v_i = 1'b1;
    tick();
    v_i = 1'b0;
    lat = 0;
    while (!v_o && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd4);
    chk({tag, "_d"}, 64'(d), 64'(exp_d));
    chk({tag, "_borrow"}, 64'(borrow), 64'(exp_b));
    yumi = 1'b1;
    tick();
    yumi = 1'b0;
    chk({tag, "_idle"}, 64'({ready, v_o}), 64'b10);
  endtask

  initial begin
    logic [32:0] m;
    int          last_acc;
    int          gap_lat;
    reset_n = 1'b0;
    v_i     = 1'b0;
    a       = '0;
    b       = '0;
    yumi    = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_v", 64'(v_o), 64'd0);
    chk("rst_d", 64'(d), 64'd0);
    chk("rst_borrow", 64'(borrow), 64'd0);

    do_op("t1", 32'h0000_0005, 32'h0000_0003,
          32'h0000_0002, 1'b0);
    do_op("t2", 32'h0000_0000, 32'h0000_0001,
          32'hFFFF_FFFF, 1'b1);
    do_op("t3", 32'h1234_5678, 32'h1234_5678,
          32'h0000_0000, 1'b0);
    do_op("t3b", 32'h0001_0000, 32'h0000_0001,
          32'h0000_FFFF, 1'b0);

    // Hold result in DONE while v_i pulses with other operands.
    a   = 32'h0000_0100;
    b   = 32'h0000_0200;
    v_i = 1'b1;
    tick();
    v_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold", 64'({ready, v_o, borrow, d}),
          {29'd0, 3'b011, 32'hFFFF_FF00});
      a   = 32'hDEAD_0000 + i;
      b   = 32'h0000_0001;
      v_i = i[0];
      tick();
    end
    v_i  = 1'b0;
    yumi = 1'b1;
    tick();
    yumi = 1'b0;
    chk("t4_release", 64'({ready, v_o}), 64'b10);
    chk("t4_nocap", 64'(d), 64'hFFFF_FF00);

    // Reset during the 2nd BUSY cycle.
    a   = 32'h0000_FFFF;
    b   = 32'h0000_0001;
    v_i = 1'b1;
    tick();
    v_i = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t5_rst", 64'({ready, v_o, borrow, d}),
        {29'd0, 3'b100, 32'd0});
    do_op("t5_op", 32'd7, 32'd2, 32'd5, 1'b0);

    // Back-to-back random pairs with immediate yumi.
    last_acc = 0;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom();
      b = (i % 7 == 0) ? a : $urandom();
      m = {1'b0, a} - {1'b0, b};
      if (i > 0) chk("t6_gap", 64'(cyc - last_acc), 64'd6);
      last_acc = cyc;
      v_i = 1'b1;
      tick();
      v_i = 1'b0;
      gap_lat = 0;
      while (!v_o && gap_lat < 20) begin
        tick();
        gap_lat++;
      end
      chk("t6_res", 64'({borrow, d}), 64'(m));
      yumi = 1'b1;
      tick();
      yumi = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
